irq_controller: RTL and testbench
=================================

# irq_controller

Parametrised interrupt controller for NMPSM3 systems; it replaces the discrete per-line set/reset flip-flops and hand-wired acknowledge OR gates. It synchronises CHANNELS asynchronous event sources (camera, VGA, other domains) into `clk` and latches rising edges as pending flags. Each flag is gated by a software-writable mask and driven to a processor IRQ line. Pending state, mask and (optionally) per-channel missed-event counts are readable through the existing port-ID bus.

## Interface
- CHANNELS, 4: number of interrupt channels, 1..16.
- SYNC_STAGES, 2: synchroniser depth per source, 2..4.
- MASK_ID, 16'h0030: port ID of the mask register (R/W).
- STATUS_ID, 16'h0031: port ID of the pending register (read; write-1-to-clear).
- MISSED_ID, 16'h0040: base port ID of the missed counters; channel n is at MISSED_ID+n (only with IRQ_MISSED_COUNT_EN).

Ports:
- clk  in  1  system clock, processor domain.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  CHANNELS  raw event sources, any clock domain; a rising edge is an event.
- irq_ack  in  CHANNELS  per-channel acknowledge from the processor (IRQ_ACKn).
- ack_alias  in  CHANNELS  per-channel extra clear; the top level ties in the shared acknowledges (e.g. ack0|ack2).
- id  in  16  port ID.
- din  in  16  processor OUT_PORT data.
- write  in  1  write strobe, one clk cycle.
- irq_out  out  CHANNELS  pending & mask, to processor IRQn.
- dout  out  16  read data to the input data MUX.

## Operation
- Sync: irq_src[n] passes through SYNC_STAGES flops; a further flop holds the previous synced value. Event = synced & ~prev.
- pending[n]:
  - Set on an event.
  - Cleared by irq_ack[n], ack_alias[n], or a STATUS_ID write with din[n]=1.
  - Set beats clear: an event in the same cycle as any clear leaves pending=1.
- mask: written from din[CHANNELS-1:0] when write && id==MASK_ID. Masked channels still latch pending; irq_out[n] = pending[n] & mask[n].
- Reads: dout is combinational from id.
  - MASK_ID returns the mask.
  - STATUS_ID returns pending.
  - MISSED_ID+n returns {8'h00, missed[n]}.
  - Any other id returns 16'h0000. Unused upper bits are 0.
- Reset values:
  - All sync and prev flops 0.
  - pending 0.
  - mask all ones, so behaviour matches the legacy always-enabled lines.
  - missed 0.
  - irq_out 0.
  - dout = f(id), i.e. 0 for non-matching id.
- Reset mid-operation clears all state immediately and asynchronously. An irq_src already high at reset release produces no event; it must fall and rise again.

## Timing
- Event latency: irq_src high meeting setup at edge k → sync[0] at k → pending=1 and irq_out=1 after edge k+SYNC_STAGES.
- Source high and low times must each be ≥ 1 clk period plus setup; shorter pulses may be lost.
- Ack latency: ack sampled high at edge j → pending=0 and irq_out=0 after edge j. Ack held for several cycles is harmless.
- Mask write at edge j takes effect on irq_out after edge j.
- STATUS write-1-to-clear follows the same set-beats-clear rule.
- No handshake on reads. dout is valid in the same cycle as id.

## Configuration
- IRQ_MISSED_COUNT_EN defined:
  - Each channel has an 8-bit saturating counter missed[n].
  - It increments when an event arrives while pending[n] is already 1 and no clear occurs in that cycle.
  - It stops at 8'hFF.
  - A write of any data to MISSED_ID+n zeroes it. If an increment coincides with that write, the result is 0.
- IRQ_MISSED_COUNT_EN undefined: no counters; reads of MISSED_ID+n return 16'h0000; writes there are ignored.

## Test plan
- Reset, then pulse irq_src[1] high for 3 cycles → irq_out=4'b0010 after edge k+2 (SYNC_STAGES=2). STATUS reads 16'h0002. Pulse irq_ack[1] → irq_out=0 next cycle.
- Write 16'h0000 to MASK_ID, then pulse irq_src[3] → irq_out stays 0 and STATUS reads 16'h0008. Write 16'h000F to MASK_ID → irq_out=4'b1000 after the write edge.
- Detect edge on channel 0 and assert ack_alias[0] in the same cycle → pending[0] stays 1. Assert ack_alias[0] alone later → cleared.
- Set pending 0, 1 and 2, then write 16'h0005 to STATUS_ID → STATUS reads 16'h0002.
- With IRQ_MISSED_COUNT_EN, raise 300 events on channel 2 with no ack → MISSED_ID+2 reads 16'h00FF. Write to MISSED_ID+2 → reads 16'h0000. Without the macro → reads 16'h0000.
- Hold irq_src[0] high, assert reset mid-operation, release it → no event and irq_out=0. Drop irq_src[0] low, then raise it → irq_out[0]=1.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: synchronised edge-latching interrupt controller; define IRQ_MISSED_COUNT_EN for per-channel missed-event counters
module irq_controller #(
  parameter int          CHANNELS    = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MASK_ID     = 16'h0030,
  parameter logic [15:0] STATUS_ID   = 16'h0031,
  parameter logic [15:0] MISSED_ID   = 16'h0040
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_src,
  input  logic [CHANNELS-1:0] irq_ack,
  input  logic [CHANNELS-1:0] ack_alias,
  input  logic [15:0]         id,
  input  logic [15:0]         din,
  input  logic                write,
  output logic [CHANNELS-1:0] irq_out,
  output logic [15:0]         dout
);
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] prev, pending, mask, evt, clr;
  logic [SYNC_STAGES:0] armed;
  logic [15:0] missed_rd;
  logic unused;
  assign evt = armed[SYNC_STAGES] ? sync[SYNC_STAGES-1] & ~prev : '0;
  assign clr = irq_ack | ack_alias | ((write && id == STATUS_ID) ? din[CHANNELS-1:0] : '0);
  assign irq_out = pending & mask;
  assign dout = id == MASK_ID ? 16'(mask) : id == STATUS_ID ? 16'(pending) : missed_rd;
  assign unused = ^din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync    <= '0;
      prev    <= '0;
      armed   <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], irq_src};
      prev    <= sync[SYNC_STAGES-1];
      armed   <= {armed[SYNC_STAGES-1:0], 1'b1};
      pending <= evt | (pending & ~clr);
      if (write && id == MASK_ID) mask <= din[CHANNELS-1:0];
    end
`ifdef IRQ_MISSED_COUNT_EN
  logic [7:0] missed [CHANNELS];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_missed
    always_ff @(posedge clk or posedge reset)
      if (reset) missed[c] <= '0;
      else if (write && id == 16'(MISSED_ID + c)) missed[c] <= '0;
      else if (evt[c] && pending[c] && !clr[c] && missed[c] != 8'hFF) missed[c] <= missed[c] + 8'd1;
  end
  always_comb begin
    missed_rd = '0;
    for (int n = 0; n < CHANNELS; n++)
      if (id == 16'(MISSED_ID + n)) missed_rd = {8'h00, missed[n]};
  end
`else
  assign missed_rd = '0;
`endif
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scoreboard-driven checks of irq_controller (CHANNELS=4, SYNC_STAGES=2)
module tb_irq_controller;
  logic clk = 0, reset = 1, write = 0;
  logic [3:0] irq_src = '0, irq_ack = '0, ack_alias = '0, irq_out;
  logic [15:0] id = '0, din = '0, dout, e;
  logic [15:0] exp_q[$];
  int checks = 0, errors = 0;

  irq_controller dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .irq_ack(irq_ack), .ack_alias(ack_alias),
    .id(id), .din(din), .write(write), .irq_out(irq_out), .dout(dout)
  );

  always #5 clk = ~clk;

  task cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task wr(input logic [15:0] a, input logic [15:0] d);
    id = a; din = d; write = 1;
    cyc(1);
    write = 0; din = '0;
  endtask

  task pulse(input int ch);
    irq_src[ch] = 1;
    cyc(2);
    irq_src[ch] = 0;
    cyc(2);
  endtask

  task test_reset;
    cyc(2);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL reset_irq irq_out=%h exp=%h", irq_out, e); end
    id = 16'h0030; exp_q.push_back(16'h000F); #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL reset_mask dout=%h exp=%h", dout, e); end
    reset = 0;
    cyc(2);
    id = 16'h0031; exp_q.push_back(16'h0000); #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL reset_status dout=%h exp=%h", dout, e); end
    id = 16'h0123; exp_q.push_back(16'h0000); #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL other_id dout=%h exp=%h", dout, e); end
    cyc(1);
  endtask

  task test_latency_ack;
    irq_src[1] = 1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002);
    cyc(2);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL lat_early irq_out=%h exp=%h", irq_out, e); end
    cyc(1);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL lat_set irq_out=%h exp=%h", irq_out, e); end
    irq_src[1] = 0;
    id = 16'h0031; exp_q.push_back(16'h0002); #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL lat_status dout=%h exp=%h", dout, e); end
    cyc(1);
    irq_ack[1] = 1; exp_q.push_back(16'h0000);
    cyc(1);
    irq_ack[1] = 0;
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL ack_clear irq_out=%h exp=%h", irq_out, e); end
    cyc(2);
  endtask

  task test_mask;
    wr(16'h0030, 16'h0000);
    pulse(3);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL mask_gated irq_out=%h exp=%h", irq_out, e); end
    id = 16'h0031; exp_q.push_back(16'h0008); #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL mask_status dout=%h exp=%h", dout, e); end
    exp_q.push_back(16'h0008);
    wr(16'h0030, 16'h000F);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL mask_enable irq_out=%h exp=%h", irq_out, e); end
    id = 16'h0030; exp_q.push_back(16'h000F); #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL mask_read dout=%h exp=%h", dout, e); end
    irq_ack[3] = 1; cyc(1); irq_ack[3] = 0; cyc(1);
  endtask

  task test_set_beats_clear;
    irq_src[0] = 1;
    cyc(2);
    ack_alias[0] = 1; exp_q.push_back(16'h0001);
    cyc(1);
    ack_alias[0] = 0;
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL set_beats_clear irq_out=%h exp=%h", irq_out, e); end
    irq_src[0] = 0;
    cyc(3);
    ack_alias[0] = 1; exp_q.push_back(16'h0000);
    cyc(1);
    ack_alias[0] = 0;
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL alias_clear irq_out=%h exp=%h", irq_out, e); end
  endtask

  task test_w1c;
    pulse(0); pulse(1); pulse(2);
    exp_q.push_back(16'h0007); exp_q.push_back(16'h0002);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL w1c_pre irq_out=%h exp=%h", irq_out, e); end
    wr(16'h0031, 16'h0005);
    id = 16'h0031; #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL w1c_status dout=%h exp=%h", dout, e); end
    wr(16'h0031, 16'h0002);
    cyc(1);
  endtask

  task test_missed;
    for (int i = 0; i < 300; i++) pulse(2);
`ifdef IRQ_MISSED_COUNT_EN
    exp_q.push_back(16'h00FF);
`else
    exp_q.push_back(16'h0000);
`endif
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    id = 16'h0042; #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL missed_sat dout=%h exp=%h", dout, e); end
    id = 16'h0041; #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL missed_other dout=%h exp=%h", dout, e); end
    wr(16'h0042, 16'h1234);
    id = 16'h0042; #1;
    e = exp_q.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL missed_zero dout=%h exp=%h", dout, e); end
    irq_ack[2] = 1; cyc(1); irq_ack[2] = 0; cyc(1);
  endtask

  task test_reset_mid;
    irq_src[0] = 1;
    cyc(4);
    #2 reset = 1; exp_q.push_back(16'h0000);
    #1;
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL async_reset irq_out=%h exp=%h", irq_out, e); end
    cyc(2);
    reset = 0; exp_q.push_back(16'h0000);
    cyc(6);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL held_src irq_out=%h exp=%h", irq_out, e); end
    irq_src[0] = 0;
    cyc(3);
    irq_src[0] = 1; exp_q.push_back(16'h0001);
    cyc(3);
    e = exp_q.pop_front(); checks++;
    if (16'(irq_out) !== e) begin errors++; $display("FAIL rearm irq_out=%h exp=%h", irq_out, e); end
    irq_src[0] = 0;
  endtask

  initial begin
    test_reset;
    test_latency_ack;
    test_mask;
    test_set_beats_clear;
    test_w1c;
    test_missed;
    test_reset_mid;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left entries=%0d exp=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
